fir_host_sequencer: RTL
=======================

Name: fir_host_sequencer

Overview:
Host-side initiator for the FIR filter's sample/coefficient handshake (sample_data, fir_coefficient, load_coeff, data_ready, modwait, fir_out, err). It buffers incoming samples in a FIFO and holds four coefficients in a register bank. It sequences coefficient loads and sample submissions against modwait, then captures each filter result. It sits between a streaming host and the fir_filter top level.

Parameters:
DEPTH, 8, sample FIFO entries; power of 2, minimum 2.
TIMEOUT, 64, max cycles a request waits for modwait to rise before abort; minimum 2.

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
sample_in  in  16  host sample
sample_valid  in  1  host sample valid
sample_ready  out  1  FIFO not full
coeff_wr  in  1  coefficient register write strobe
coeff_addr  in  2  coefficient index 0..3
coeff_wdata  in  16  coefficient value
coeff_start  in  1  pulse: load all 4 coefficients into filter
coeff_loaded  out  1  full coefficient set accepted by filter
sample_data  out  16  to filter
fir_coefficient  out  16  to filter
load_coeff  out  1  to filter
data_ready  out  1  to filter
modwait  in  1  from filter
fir_out  in  16  from filter
err  in  1  from filter
result_data  out  16  captured fir_out
result_valid  out  1  one-cycle result strobe
result_err  out  1  err captured with result
timeout  out  1  sticky request-timeout flag

Behaviour:
- Reset (async): all outputs 0; FIFO empty; coeff regs 0; FSM IDLE; coeff pending flag clear. Reset mid-transaction drops load_coeff/data_ready immediately.
- FIFO: push when sample_valid && sample_ready; sample_ready = !full. Pop happens on the IDLE->SAMP_REQ transition. A sample pushed into an empty FIFO is eligible for issue the following cycle. Occupancy never wraps: no push when full, no pop when empty.
- Coeff regs: coeff_wr writes coeff_addr when FSM not in COEFF_*; ignored during loading. coeff_start sets pending; clears coeff_loaded.
- FSM states: IDLE, COEFF_REQ, COEFF_WAIT, SAMP_REQ, SAMP_WAIT.
- IDLE: a request is issued only when modwait==0. Coeff pending has priority over a non-empty FIFO. Coeff path: idx<=0, go COEFF_REQ. Sample path: pop into sample_data, go SAMP_REQ.
- COEFF_REQ: load_coeff=1, fir_coefficient=coeff[idx] held stable. On modwait==1, go COEFF_WAIT with load_coeff=0.
- COEFF_WAIT: on modwait==0, either idx++ and return to COEFF_REQ, or, when idx==3, set coeff_loaded, clear pending and go IDLE.
- SAMP_REQ: data_ready=1, sample_data held stable. On modwait==1, go SAMP_WAIT with data_ready=0.
- SAMP_WAIT: on modwait==0, register result_data<=fir_out and result_err<=err, pulse result_valid for one cycle, go IDLE.
- Latency: result_valid asserts exactly 1 cycle after the cycle modwait is sampled low in SAMP_WAIT.
- Timeout: a 16-bit counter runs in *_REQ and resets on state entry. After TIMEOUT cycles without modwait high:
  - drop the request, set timeout (sticky until reset), go IDLE;
  - a dropped sample is discarded;
  - a coeff load leaves pending set and coeff_loaded=0, so the load retries from idx 0.
- Simultaneous events: coeff_start arriving during SAMP_* is deferred to IDLE. coeff_start and coeff_wr in the same cycle: the write lands, then the load uses the new value. A FIFO push in the same cycle as a pop is allowed.
- load_coeff and data_ready are never asserted together.

Test Plan:
1. Write coeff 0..3 = 0x0001,0x0002,0x0003,0x0004; pulse coeff_start; model modwait high 2 cycles after each load_coeff -> fir_coefficient sequence 1,2,3,4, each held until modwait rises; coeff_loaded=1 after 4th modwait fall.
2. Push 0x1234 with model returning fir_out=0x00AA, err=0 -> sample_data=0x1234 with data_ready until modwait rises; result_data=0x00AA, result_valid one cycle.
3. Push 9 samples back-to-back with modwait held high -> sample_ready low after 8 accepted; 9th held off by host; once modwait releases, all 8 are issued in order.
4. coeff_start during SAMP_WAIT -> sample result completes first, then coefficient load begins; data_ready and load_coeff never high together.
5. Model never raises modwait -> after 64 cycles data_ready drops, timeout=1, FIFO advances to next sample.
6. Assert n_reset low while in COEFF_REQ -> load_coeff=0 asynchronously, FIFO empty, coeff_loaded=0, timeout=0.

Source files
------------

// File: rtl/fir_host_sequencer.sv
// Host-side initiator for the FIR filter: buffers samples, holds a 4-entry
// coefficient bank and sequences load_coeff/data_ready requests against modwait.
module fir_host_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        coeff_wr,
  input  logic [1:0]  coeff_addr,
  input  logic [15:0] coeff_wdata,
  input  logic        coeff_start,
  output logic        coeff_loaded,
  output logic [15:0] sample_data,
  output logic [15:0] fir_coefficient,
  output logic        load_coeff,
  output logic        data_ready,
  input  logic        modwait,
  input  logic [15:0] fir_out,
  input  logic        err,
  output logic [15:0] result_data,
  output logic        result_valid,
  output logic        result_err,
  output logic        timeout
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, COEFF_REQ, COEFF_WAIT, SAMP_REQ, SAMP_WAIT} state_t;
  state_t state, state_nxt;

  logic [15:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [15:0]   coeff [4];
  logic [1:0]    idx;
  logic          pending;
  logic [15:0]   tcnt;
  logic          push, pop, in_req, req_expired, coeff_busy, coeff_done, req_abort;

  assign push        = sample_valid && sample_ready;
  assign pop         = (state == IDLE) && (state_nxt == SAMP_REQ);
  assign count_nxt   = count + (AW+1)'(push) - (AW+1)'(pop);
  assign in_req      = (state == COEFF_REQ) || (state == SAMP_REQ);
  assign req_expired = (tcnt == 16'(TIMEOUT - 1));
  assign req_abort   = in_req && !modwait && req_expired;
  assign coeff_busy  = (state == COEFF_REQ) || (state == COEFF_WAIT);
  assign coeff_done  = (state == COEFF_WAIT) && !modwait && (idx == 2'd3);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // A pending coefficient load wins over queued samples; nothing is issued while modwait is high.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!modwait) begin
          if (pending)             state_nxt = COEFF_REQ;
          else if (count != '0)    state_nxt = SAMP_REQ;
        end
      end
      COEFF_REQ:  if (modwait) state_nxt = COEFF_WAIT; else if (req_expired) state_nxt = IDLE;
      COEFF_WAIT: if (!modwait) state_nxt = (idx == 2'd3) ? IDLE : COEFF_REQ;
      SAMP_REQ:   if (modwait) state_nxt = SAMP_WAIT;  else if (req_expired) state_nxt = IDLE;
      SAMP_WAIT:  if (!modwait) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_coeff      = (state == COEFF_REQ);
    data_ready      = (state == SAMP_REQ);
    fir_coefficient = '0;
    if (coeff_busy) fir_coefficient = coeff[idx];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sample_ready <= 1'b0;
      sample_data  <= '0;
      coeff        <= '{default: '0};
      idx          <= '0;
      pending      <= 1'b0;
      coeff_loaded <= 1'b0;
      tcnt         <= '0;
      timeout      <= 1'b0;
      result_data  <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      count        <= count_nxt;
      sample_ready <= (count_nxt != (AW+1)'(DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        sample_data <= fifo_mem[rd_ptr];
      end
      if (coeff_wr && !coeff_busy) coeff[coeff_addr] <= coeff_wdata;
      if ((state == IDLE) && (state_nxt == COEFF_REQ))            idx <= '0;
      else if ((state == COEFF_WAIT) && (state_nxt == COEFF_REQ)) idx <= idx + 2'd1;
      // Counter restarts on every state change, so it measures time spent in the current request.
      tcnt <= (in_req && (state_nxt == state)) ? tcnt + 16'd1 : '0;
      if (req_abort) timeout <= 1'b1;
      if (coeff_start) begin
        pending      <= 1'b1;
        coeff_loaded <= 1'b0;
      end else if (coeff_done) begin
        pending      <= 1'b0;
        coeff_loaded <= 1'b1;
      end
      result_valid <= 1'b0;
      if ((state == SAMP_WAIT) && !modwait) begin
        result_valid <= 1'b1;
        result_data  <= fir_out;
        result_err   <= err;
      end
    end
  end
endmodule
